// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - three-way round-robin arbiter for one shared single-port synchronous memory
//
// Ports:
//   clock, reset                        rising-edge clock, synchronous active-high reset
//   f_req, f_addr, f_gnt, f_rvalid      instruction fetch requester (always reads)
//   d_req, d_we, d_addr, d_wdata,
//   d_gnt, d_rvalid                     CPU data load/store requester
//   x_req, x_we, x_addr, x_wdata,
//   x_lock, x_gnt, x_rvalid             external loader/debug requester, may lock the bus
//   rdata                               shared read data, passed straight from mem_rdata
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata                memory side; read data arrives one cycle after the grant
module mem_bus_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,

    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    input  logic              x_lock,
    output logic              x_gnt,
    output logic              x_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Requester indices; also the encoding held in 'last'.
    localparam logic [1:0] IDX_F = 2'd0;
    localparam logic [1:0] IDX_D = 2'd1;
    localparam logic [1:0] IDX_X = 2'd2;

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_t;

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic [2:0]       req;
    logic [2:0]       gnt;
    logic [1:0]       winner;

    // Saturating increment of the lock counter.
    assign cnt_inc = (lock_cnt == CNT_MAX) ? CNT_MAX : lock_cnt + CNT_ONE;

    // Winner selection. The requester after 'last' gets first pick, so the
    // previous winner is always considered last.
    always_comb begin
        req    = {x_req, d_req, f_req};
        gnt    = '0;
        winner = IDX_F;
        if (!reset) begin
            if (state == ST_LOCK) begin
                // Bus belongs to X; other requests simply wait.
                winner = IDX_X;
            end else begin
                case (last)
                    IDX_F: begin
                        if (req[IDX_D])      winner = IDX_D;
                        else if (req[IDX_X]) winner = IDX_X;
                        else                 winner = IDX_F;
                    end
                    IDX_D: begin
                        if (req[IDX_X])      winner = IDX_X;
                        else if (req[IDX_F]) winner = IDX_F;
                        else                 winner = IDX_D;
                    end
                    default: begin
                        if (req[IDX_F])      winner = IDX_F;
                        else if (req[IDX_D]) winner = IDX_D;
                        else                 winner = IDX_X;
                    end
                endcase
            end
            // The fall-through choice only yields a grant if it actually requests.
            gnt[winner] = req[winner];
        end
    end

    assign f_gnt = gnt[IDX_F];
    assign d_gnt = gnt[IDX_D];
    assign x_gnt = gnt[IDX_X];

    // Memory-side mux; idle bus is driven to all zeros.
    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[IDX_F]) begin
            mem_addr  = f_addr;
        end else if (gnt[IDX_D]) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (gnt[IDX_X]) begin
            mem_we    = x_we;
            mem_addr  = x_addr;
            mem_wdata = x_wdata;
        end
    end

    assign rdata = mem_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_ARB;
            last     <= IDX_X;
            lock_cnt <= '0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            x_rvalid <= 1'b0;
        end else begin
            // One-cycle read return tag, matching the memory's read latency.
            f_rvalid <= gnt[IDX_F];
            d_rvalid <= gnt[IDX_D] & ~d_we;
            x_rvalid <= gnt[IDX_X] & ~x_we;

            case (state)
                ST_ARB: begin
                    if (|gnt) begin
                        last <= winner;
                    end
                    // A single permitted grant leaves nothing to lock.
                    if (gnt[IDX_X] && x_lock && (MAX_LOCK > 1)) begin
                        state    <= ST_LOCK;
                        lock_cnt <= CNT_ONE;
                    end
                end
                ST_LOCK: begin
                    if (gnt[IDX_X]) begin
                        lock_cnt <= cnt_inc;
                    end
                    // Voluntary release, or forced release once the burst budget is spent.
                    if (!x_lock || (gnt[IDX_X] && (cnt_inc == CNT_MAX))) begin
                        state    <= ST_ARB;
                        last     <= IDX_X;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int MAX_LOCK = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              preload_en = 1'b1;
    logic              f_req = 1'b0, d_req = 1'b0, x_req = 1'b0;
    logic              d_we = 1'b0, x_we = 1'b0, x_lock = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0, d_addr = '0, x_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0, x_wdata = '0;
    logic              f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid;
    logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_lock(x_lock), .x_gnt(x_gnt), .x_rvalid(x_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input int i);
        return (i == 16) ? 8'h3C : 8'(i * 7 + 3);
    endfunction

    // Single-port synchronous 256x8 memory attached to the arbiter.
    logic [7:0] mem [256];
    always @(posedge clock) begin
        if (preload_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbiter + scoreboard of expected read returns.
    typedef struct {
        int         cyc;
        logic [1:0] who;
        logic [7:0] data;
    } rd_t;

    rd_t        sb[$];
    logic [7:0] shadow [256];
    int         cyc_n  = 0;
    bit         m_lock = 0;
    int         m_last = 2;
    int         m_cnt  = 0;

    always @(negedge clock) begin
        logic [2:0] rq, eg, ev;
        logic       e_we;
        logic [7:0] e_addr, e_wd;
        int         w, idx;
        rd_t        rd;

        if (preload_en) for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

        rq = {x_req, d_req, f_req};
        eg = '0;
        w  = -1;
        if (!reset) begin
            if (m_lock) begin
                if (x_req) w = 2;
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    idx = (m_last + k) % 3;
                    if (w < 0 && rq[idx]) w = idx;
                end
            end
            if (w >= 0) eg[w] = 1'b1;
        end

        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (w == 0) begin
            e_addr = f_addr;
        end else if (w == 1) begin
            e_we = d_we; e_addr = d_addr; e_wd = d_wdata;
        end else if (w == 2) begin
            e_we = x_we; e_addr = x_addr; e_wd = x_wdata;
        end

        chk("gnt", {29'd0, x_gnt, d_gnt, f_gnt}, {29'd0, eg});
        chk("mem_en", {31'd0, mem_en}, {31'd0, |eg});
        chk("mem_bus", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, e_we, e_addr, e_wd});

        if (reset) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc_n) void'(sb.pop_front());
        end else begin
            ev = '0;
            if (sb.size() > 0 && sb[0].cyc == cyc_n) begin
                rd = sb.pop_front();
                ev[rd.who] = 1'b1;
                chk("rdata", {24'd0, rdata}, {24'd0, rd.data});
            end
            chk("rvalid", {29'd0, x_rvalid, d_rvalid, f_rvalid}, {29'd0, ev});
        end

        if (reset) begin
            m_lock = 0; m_last = 2; m_cnt = 0;
        end else begin
            if (w >= 0) begin
                if (!e_we) sb.push_back('{cyc_n + 1, 2'(w), shadow[e_addr]});
                else       shadow[e_addr] = e_wd;
            end
            if (!m_lock) begin
                if (w >= 0) m_last = w;
                if (w == 2 && x_lock) begin m_lock = 1; m_cnt = 1; end
            end else begin
                if (w == 2) m_cnt++;
                if (!x_lock || m_cnt >= MAX_LOCK) begin m_lock = 0; m_last = 2; end
            end
        end
        cyc_n++;
    end

    typedef struct {
        logic       f, d, x, xwe, xl;
        logic [2:0] eg;   // {x,d,f}
    } vec_t;
    vec_t tv [13];

    task automatic drive(input logic f, input logic d, input logic x,
                         input logic dwe, input logic xwe, input logic xl);
        f_req = f; d_req = d; x_req = x; d_we = dwe; x_we = xwe; x_lock = xl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tv[0]  = '{1, 1, 1, 0, 0, 3'b001};
        tv[1]  = '{1, 1, 1, 0, 0, 3'b010};
        tv[2]  = '{1, 1, 1, 0, 0, 3'b100};
        tv[3]  = '{1, 1, 1, 0, 0, 3'b001};
        tv[4]  = '{1, 1, 1, 0, 0, 3'b010};
        tv[5]  = '{1, 1, 1, 1, 1, 3'b100};
        tv[6]  = '{1, 1, 1, 1, 1, 3'b100};
        tv[7]  = '{1, 1, 1, 1, 1, 3'b100};
        tv[8]  = '{1, 1, 1, 1, 0, 3'b100};
        tv[9]  = '{1, 1, 0, 0, 0, 3'b001};
        tv[10] = '{1, 1, 0, 0, 0, 3'b010};
        tv[11] = '{1, 1, 1, 0, 0, 3'b100};
        tv[12] = '{1, 1, 1, 0, 0, 3'b001};

        // Reset with everyone requesting: no grant may leak out.
        drive(1, 1, 1, 0, 0, 0);
        @(negedge clock);
        chk("reset_gnt", {29'd0, x_gnt, d_gnt, f_gnt}, 32'd0);
        chk("reset_mem", {30'd0, mem_en, mem_we}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        preload_en = 1'b0;
        reset      = 1'b0;

        // Rotation, then a locked 4-write X burst that F cannot break into.
        for (int i = 0; i < 13; i++) begin
            drive(tv[i].f, tv[i].d, tv[i].x, 1'b0, tv[i].xwe, tv[i].xl);
            f_addr  = 8'(i);
            d_addr  = 8'(8'h80 + i);
            x_addr  = 8'(8'hC0 + i);
            x_wdata = 8'(8'hE0 + i);
            @(negedge clock);
            chk($sformatf("vec%0d", i), {29'd0, x_gnt, d_gnt, f_gnt}, {29'd0, tv[i].eg});
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // F alone reads the preloaded location.
        f_addr = 8'h10;
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("t2_f_gnt", {31'd0, f_gnt}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("t2_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("t2_rdata", {24'd0, rdata}, 32'h3C);
        chk("t2_dx_rvalid", {30'd0, d_rvalid, x_rvalid}, 32'd0);
        tick();

        // D stores, X reads it back.
        d_addr = 8'h20; d_wdata = 8'hA5;
        drive(0, 1, 0, 1, 0, 0);
        @(negedge clock);
        chk("t3_d_gnt", {31'd0, d_gnt}, 32'd1);
        tick();
        x_addr = 8'h20;
        drive(0, 0, 1, 0, 0, 0);
        @(negedge clock);
        chk("t3_store_rvalid", {29'd0, x_rvalid, d_rvalid, f_rvalid}, 32'd0);
        chk("t3_x_gnt", {31'd0, x_gnt}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("t3_x_rvalid", {31'd0, x_rvalid}, 32'd1);
        chk("t3_rdata", {24'd0, rdata}, 32'hA5);
        tick();

        // Forced release after MAX_LOCK locked X grants.
        drive(0, 1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 0, 0, 1);
        for (int n = 0; n < MAX_LOCK; n++) begin
            @(negedge clock);
            chk($sformatf("t5_x%0d", n), {29'd0, x_gnt, d_gnt, f_gnt}, 32'b100);
            tick();
        end
        @(negedge clock);
        chk("t5_after_f", {29'd0, x_gnt, d_gnt, f_gnt}, 32'b001);
        tick();
        @(negedge clock);
        chk("t5_after_d", {29'd0, x_gnt, d_gnt, f_gnt}, 32'b010);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // Reset in the middle of a lock with a read return pending.
        x_addr = 8'h33;
        drive(1, 0, 1, 0, 0, 1);
        @(negedge clock);
        chk("t6_enter_lock", {29'd0, x_gnt, d_gnt, f_gnt}, 32'b100);
        tick();
        @(negedge clock);
        chk("t6_locked_read", {29'd0, x_gnt, d_gnt, f_gnt}, 32'b100);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("t6_reset_gnt", {29'd0, x_gnt, d_gnt, f_gnt}, 32'd0);
        chk("t6_reset_mem", {30'd0, mem_en, mem_we}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_first_f", {29'd0, x_gnt, d_gnt, f_gnt}, 32'b001);
        chk("t6_rvalid_cleared", {31'd0, x_rvalid}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("t6_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port synchronous 256x8 memory between three requesters: CPU instruction fetch (F), CPU data load/store (D) and the external loader/debug port (X).
- The CPU moves from split instruction/data memories to a unified memory; this block replaces the direct instr_mem/data_mem hookup.
- Round-robin arbitration with a bounded burst lock for the loader. Read data is returned one cycle after the grant.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
MAX_LOCK, 16, maximum consecutive locked X grants before a forced release

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
f_req  in  1  fetch read request; held until f_gnt
f_addr  in  ADDR_W  fetch address (pc)
f_gnt  out  1  fetch granted this cycle
f_rvalid  out  1  rdata valid for fetch
d_req  in  1  data access request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data access granted this cycle
d_rvalid  out  1  rdata valid for a data load
x_req  in  1  external request; held until x_gnt
x_we  in  1  1 = write, 0 = read
x_addr  in  ADDR_W  external address
x_wdata  in  DATA_W  external write data
x_lock  in  1  external request to keep the bus after this grant
x_gnt  out  1  external access granted this cycle
x_rvalid  out  1  rdata valid for an external read
rdata  out  DATA_W  shared read data (mem_rdata passthrough)
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after a read enable

Behaviour:
Reset (synchronous, active-high):
- state = ARB, last = 2 (so F has top priority), lock_cnt = 0, all rvalid = 0.
- All gnt, mem_en and mem_we are forced to 0 for every cycle reset is high.
- Reset while in LOCK returns to ARB.

Grants:
- Combinational from the req inputs and registered state. At most one gnt per cycle. A request is granted in the same cycle it is presented if it wins.
- Memory side: mem_en = OR of the gnts. mem_we, mem_addr and mem_wdata are muxed from the winner; F always reads.
- With no grant: mem_en = mem_we = 0, and mem_addr = mem_wdata = 0.

ARB state:
- Priority order starts at index (last+1) mod 3, with F=0, D=1, X=2. The first requester in that order wins.
- On any grant, last <= winner index.
- If X wins with x_lock = 1: next state = LOCK, lock_cnt <= 1.

LOCK state:
- Only X can be granted; f_gnt = d_gnt = 0 even when x_req = 0.
- Each X grant increments lock_cnt.
- Exit to ARB at the edge where x_lock = 0, or where lock_cnt reaches MAX_LOCK (forced release).
- On exit, last = 2, so F, then D, outrank X at the next arbitration.

Read return:
- A granted read (we = 0) sets that requester's rvalid for exactly the next cycle.
- rdata = mem_rdata at all times. Writes produce no rvalid.
- Back-to-back reads by different requesters give consecutive single-cycle rvalid pulses to the respective owners.

Simultaneous events:
- Requests and rvalid of a previous grant coexist; a new grant is never blocked by a pending rvalid.
- Requests arriving in LOCK wait, with no loss, until release.

Width rules:
- No arithmetic on data.
- lock_cnt is wide enough for MAX_LOCK and saturates at MAX_LOCK.

Test Plan:
1. Reset, then F,D,X all request every cycle → grants rotate F,D,X,F,D,X. After reset, F is granted first.
2. Memory preloaded with 0x3C at 0x10; F reads 0x10 (only requester) → f_gnt on cycle N, f_rvalid = 1 and rdata = 0x3C on cycle N+1, d/x_rvalid = 0.
3. D stores 0xA5 at 0x20 (d_we = 1), then X reads 0x20 → no rvalid on the store, x_rvalid with rdata = 0xA5 one cycle after x_gnt.
4. X bursts 4 writes with x_lock = 1 while F requests constantly → f_gnt = 0 for 4 cycles. x_lock drops with the 4th write; F is granted the next cycle.
5. MAX_LOCK = 16, X holds x_lock = 1 with F/D requesting → after 16 X grants, forced release; the next grants go to F then D before X.
6. Assert reset for 1 cycle mid-LOCK with a read outstanding → the pending rvalid is cleared, no gnt during reset, state = ARB, and the next grant goes to F.
